// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO recovery controller: state encoding,
// sticky-bit positions and a constant-evaluable ceil(log2) helper.
package fifo_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    FLUSH   = 3'd2,
    HOLDOFF = 3'd3,
    FAULT   = 3'd4
  } state_e;

  localparam int STICKY_OVF = 0;
  localparam int STICKY_UNF = 1;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_recovery_ctrl_sat_counter.sv
// Saturating event counter; an increment in the same cycle as a clear
// leaves the counter at 1.
module sat_counter
  import fifo_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc) begin
      if (clr) begin
        count_d = CNT_W'(1);
      end else if (count_q != '1) begin
        count_d = count_q + 1'b1;
      end
    end else if (clr) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fifo_recovery_ctrl.sv
// FIFO overflow/underflow recovery sequencer with sticky status and optional
// saturating event counters (enabled by FIFO_RECOVERY_STATS_EN).
module fifo_recovery_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int CLEAR_CYCLES   = 4,
  parameter int HOLDOFF_CYCLES = 8,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             auto_recover,
  input  logic             host_clear,
  input  logic             clr_status,
  input  logic             wr_overflow,
  input  logic             rd_underflow,
  output logic             fifo_clear,
  output logic             data_gate,
  output logic             busy,
  output logic             fault,
  output logic [1:0]       sticky,
  output logic [CNT_W-1:0] ovf_count,
  output logic [CNT_W-1:0] unf_count
);

  localparam int TMR_MAX = (CLEAR_CYCLES > HOLDOFF_CYCLES) ? CLEAR_CYCLES : HOLDOFF_CYCLES;
  localparam int TMR_W   = clog2(TMR_MAX) + 1;
  localparam int RTY_W   = clog2(MAX_RETRY) + 1;
  localparam logic [TMR_W-1:0] CLR_LOAD  = TMR_W'(CLEAR_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLDOFF_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_LAST  = RTY_W'(MAX_RETRY - 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             ovf_prev_q, unf_prev_q;
  logic             fifo_clear_q, data_gate_q, busy_q, fault_q;
  logic [1:0]       sticky_q, sticky_d;

  logic ovf_rise, unf_rise, timer_zero, final_chk, ovf_ev, unf_ev;

  assign ovf_rise   = wr_overflow & ~ovf_prev_q;
  assign unf_rise   = rd_underflow & ~unf_prev_q;
  assign timer_zero = (timer_q == '0);
  assign final_chk  = (state_q == HOLDOFF) && timer_zero;

  // A flag still set at the end of hold-off counts as a fresh event.
  assign ovf_ev = ((state_q == RUN) & ovf_rise) | (final_chk & wr_overflow);
  assign unf_ev = ((state_q == RUN) & unf_rise) | (final_chk & rd_underflow);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    if (!enable) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = FLUSH;
          timer_d = CLR_LOAD;
          retry_d = '0;
        end
        RUN: begin
          if (host_clear || (auto_recover && (ovf_rise || unf_rise))) begin
            state_d = FLUSH;
            timer_d = CLR_LOAD;
            retry_d = '0;
          end
        end
        FLUSH: begin
          if (timer_zero) begin
            state_d = HOLDOFF;
            timer_d = HOLD_LOAD;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        HOLDOFF: begin
          if (host_clear) begin
            state_d = FLUSH;
            timer_d = CLR_LOAD;
            retry_d = '0;
          end else if (!timer_zero) begin
            timer_d = timer_q - 1'b1;
          end else if (!wr_overflow && !rd_underflow) begin
            state_d = RUN;
            timer_d = '0;
          end else if (retry_q < RTY_LAST) begin
            state_d = FLUSH;
            timer_d = CLR_LOAD;
            retry_d = retry_q + 1'b1;
          end else begin
            state_d = FAULT;
            timer_d = '0;
          end
        end
        FAULT: begin
          if (host_clear) begin
            state_d = FLUSH;
            timer_d = CLR_LOAD;
            retry_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    sticky_d = clr_status ? 2'b00 : sticky_q;
    sticky_d[STICKY_OVF] = sticky_d[STICKY_OVF] | ovf_ev;
    sticky_d[STICKY_UNF] = sticky_d[STICKY_UNF] | unf_ev;
  end

  // Outputs are decoded from the next state so they change on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      retry_q      <= '0;
      ovf_prev_q   <= 1'b0;
      unf_prev_q   <= 1'b0;
      fifo_clear_q <= 1'b0;
      data_gate_q  <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      sticky_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      ovf_prev_q   <= wr_overflow;
      unf_prev_q   <= rd_underflow;
      fifo_clear_q <= (state_d == FLUSH);
      data_gate_q  <= (state_d == RUN);
      busy_q       <= (state_d == FLUSH) || (state_d == HOLDOFF);
      fault_q      <= (state_d == FAULT);
      sticky_q     <= sticky_d;
    end
  end

  assign fifo_clear = fifo_clear_q;
  assign data_gate  = data_gate_q;
  assign busy       = busy_q;
  assign fault      = fault_q;
  assign sticky     = sticky_q;

`ifdef FIFO_RECOVERY_STATS_EN
  sat_counter #(.CNT_W(CNT_W)) u_ovf_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ovf_ev),
    .clr   (clr_status),
    .count (ovf_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_unf_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (unf_ev),
    .clr   (clr_status),
    .count (unf_count)
  );
`else
  assign ovf_count = '0;
  assign unf_count = '0;
`endif

endmodule

// File: tb/tb_fifo_recovery_ctrl.sv
// Directed bench for fifo_recovery_ctrl: expected output tuples are queued
// when a stimulus step is driven and popped one per clock for comparison.
module tb_fifo_recovery_ctrl;

`ifdef FIFO_RECOVERY_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, auto_recover, host_clear, clr_status;
  logic        wr_overflow, rd_underflow;
  logic        fifo_clear, data_gate, busy, fault;
  logic [1:0]  sticky;
  logic [15:0] ovf_count, unf_count;
  logic        fifo_clear4, data_gate4, busy4, fault4;
  logic [1:0]  sticky4;
  logic [3:0]  ovf_count4, unf_count4;

  fifo_recovery_ctrl #(.CLEAR_CYCLES(4), .HOLDOFF_CYCLES(8), .MAX_RETRY(3), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .auto_recover(auto_recover),
    .host_clear(host_clear), .clr_status(clr_status),
    .wr_overflow(wr_overflow), .rd_underflow(rd_underflow),
    .fifo_clear(fifo_clear), .data_gate(data_gate), .busy(busy), .fault(fault),
    .sticky(sticky), .ovf_count(ovf_count), .unf_count(unf_count)
  );

  fifo_recovery_ctrl #(.CLEAR_CYCLES(4), .HOLDOFF_CYCLES(8), .MAX_RETRY(3), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .enable(enable), .auto_recover(auto_recover),
    .host_clear(host_clear), .clr_status(clr_status),
    .wr_overflow(wr_overflow), .rd_underflow(rd_underflow),
    .fifo_clear(fifo_clear4), .data_gate(data_gate4), .busy(busy4), .fault(fault4),
    .sticky(sticky4), .ovf_count(ovf_count4), .unf_count(unf_count4)
  );

  typedef struct packed {
    logic clr;
    logic gate;
    logic bsy;
    logic flt;
  } outs_t;

  localparam outs_t O_IDLE  = 4'b0000;
  localparam outs_t O_FLUSH = 4'b1010;
  localparam outs_t O_HOLD  = 4'b0010;
  localparam outs_t O_RUN   = 4'b0100;
  localparam outs_t O_FAULT = 4'b0001;

  outs_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int exp_ovf = 0;
  int exp_unf = 0;
  logic [1:0] exp_sticky = 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_cnt(input int n, input int w);
    int mx;
    if (!STATS) return 32'd0;
    mx = (1 << w) - 1;
    return (n > mx) ? 32'(mx) : 32'(n);
  endfunction

  function automatic outs_t cur();
    return outs_t'({fifo_clear, data_gate, busy, fault});
  endfunction

  task automatic push_n(input outs_t v, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(v);
  endtask

  task automatic push_round();
    push_n(O_FLUSH, 4);
    push_n(O_HOLD, 8);
  endtask

  task automatic drain(input int n, input string tag);
    outs_t e;
    for (int i = 0; i < n; i++) begin
      if (sb_q.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        return;
      end
      tick();
      e = sb_q.pop_front();
      chk($sformatf("%s[%0d]", tag, i), 32'(cur()), 32'(e));
    end
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_sticky"}, 32'(sticky), 32'(exp_sticky));
    chk({tag, "_ovf"}, 32'(ovf_count), exp_cnt(exp_ovf, 16));
    chk({tag, "_unf"}, 32'(unf_count), exp_cnt(exp_unf, 16));
    chk({tag, "_ovf4"}, 32'(ovf_count4), exp_cnt(exp_ovf, 4));
  endtask

  task automatic pulse_ovf();
    wr_overflow = 1'b1;
    tick();
    wr_overflow = 1'b0;
    tick();
    exp_ovf++;
    exp_sticky[0] = 1'b1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; auto_recover = 1'b0; host_clear = 1'b0;
    clr_status = 1'b0; wr_overflow = 1'b0; rd_underflow = 1'b0;
    tick();
    tick();
    chk("reset_outs", 32'(cur()), 32'(O_IDLE));
    chk_stats("reset");
    reset = 1'b0;
    tick();
    chk("idle_outs", 32'(cur()), 32'(O_IDLE));

    // Enable: FIFO is flushed first, data_gate on the 13th cycle.
    enable = 1'b1;
    push_round();
    push_n(O_RUN, 3);
    drain(15, "enable_seq");

    // Auto-recover on a one-cycle overflow pulse.
    auto_recover = 1'b1;
    wr_overflow = 1'b1;
    push_round();
    push_n(O_RUN, 2);
    drain(1, "auto_seq");
    wr_overflow = 1'b0;
    drain(13, "auto_seq");
    exp_ovf = 1; exp_sticky = 2'b01;
    chk_stats("auto");

    // Without auto_recover only the statistics move.
    auto_recover = 1'b0;
    pulse_ovf();
    chk("noauto_gate", 32'(cur()), 32'(O_RUN));
    rd_underflow = 1'b1;
    tick();
    rd_underflow = 1'b0;
    tick();
    exp_unf = 1; exp_sticky = 2'b11;
    chk("noauto_gate2", 32'(cur()), 32'(O_RUN));
    chk_stats("noauto");

    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    exp_ovf = 0; exp_unf = 0; exp_sticky = 2'b00;
    chk_stats("clr");

    // Overflow held: three failed rounds then FAULT; each recheck counts.
    auto_recover = 1'b1;
    wr_overflow = 1'b1;
    push_round(); push_round(); push_round();
    push_n(O_FAULT, 2);
    drain(38, "retry_seq");
    exp_ovf = 4; exp_sticky = 2'b01;
    chk_stats("fault");
    wr_overflow = 1'b0;
    auto_recover = 1'b0;
    tick();
    chk("fault_hold", 32'(cur()), 32'(O_FAULT));
    host_clear = 1'b1;
    push_round();
    push_n(O_RUN, 1);
    drain(1, "fault_exit");
    host_clear = 1'b0;
    drain(12, "fault_exit");
    chk_stats("fault_exit");

    // host_clear on the 5th hold-off cycle restarts the whole flush.
    host_clear = 1'b1;
    push_n(O_FLUSH, 4);
    push_n(O_HOLD, 5);
    drain(1, "hc_hold");
    host_clear = 1'b0;
    drain(8, "hc_hold");
    host_clear = 1'b1;
    push_round();
    push_n(O_RUN, 1);
    drain(1, "hc_restart");
    host_clear = 1'b0;
    drain(12, "hc_restart");

    // 20 rises: 16-bit counter follows, 4-bit counter pins at 15.
    for (int i = 0; i < 20; i++) pulse_ovf();
    chk("sat_gate", 32'(cur()), 32'(O_RUN));
    chk_stats("sat");

    // Clear coincident with a rise: the event wins.
    clr_status = 1'b1;
    wr_overflow = 1'b1;
    tick();
    clr_status = 1'b0;
    wr_overflow = 1'b0;
    tick();
    exp_ovf = 1; exp_unf = 0; exp_sticky = 2'b01;
    chk_stats("clr_vs_ev");

    // Drop enable in the middle of FLUSH.
    host_clear = 1'b1;
    tick();
    host_clear = 1'b0;
    chk("mid_flush", 32'(cur()), 32'(O_FLUSH));
    tick();
    enable = 1'b0;
    tick();
    chk("disable_outs", 32'(cur()), 32'(O_IDLE));
    tick();
    chk("disable_hold", 32'(cur()), 32'(O_IDLE));
    chk_stats("disable");
    enable = 1'b1;
    push_round();
    push_n(O_RUN, 1);
    drain(13, "reenable_seq");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
